// File: rtl/e203_exu_fpu_cmp_wbck_pkg.sv
// Shared FPU compare writeback definitions: source encodings and result constants.
package e203_exu_fpu_cmp_wbck_pkg;

  typedef enum logic [1:0] {
    CMP_SRC_EQ = 2'd0,
    CMP_SRC_LT = 2'd1,
    CMP_SRC_LE = 2'd2
  } cmp_src_e;

  localparam logic [31:0] FCMP_TRUE  = 32'h1;
  localparam logic [31:0] FCMP_FALSE = 32'h0;

  // Successor in the three-way round-robin ring.
  function automatic logic [1:0] rr_next(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  function automatic logic [31:0] fcmp_norm(input logic [31:0] x);
    return (|x) ? FCMP_TRUE : FCMP_FALSE;
  endfunction

endpackage

// File: rtl/e203_exu_fpu_cmp_wbck_fifo.sv
// Small synchronous FIFO holding normalized compare results; head is read combinationally.
module e203_exu_fpu_cmp_wbck_fifo #(
  parameter int W     = 39,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] LAST = AW'(DEPTH - 1);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]  count_q, count_d;

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign dout_o  = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem[wr_ptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/e203_exu_fpu_cmp_wbck.sv
// Round-robin writeback collector for feq/flt/fle results into one integer writeback port.
// Optional same-cycle bypass when the FIFO is empty: define E203_FPU_CMP_WBCK_BYPASS_EN.
module e203_exu_fpu_cmp_wbck
  import e203_exu_fpu_cmp_wbck_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int RDW   = 5
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           eq_i_valid,
  output logic           eq_i_ready,
  input  logic [31:0]    eq_i_wdat,
  input  logic [RDW-1:0] eq_i_rdidx,
  input  logic           lt_i_valid,
  output logic           lt_i_ready,
  input  logic [31:0]    lt_i_wdat,
  input  logic [RDW-1:0] lt_i_rdidx,
  input  logic           le_i_valid,
  output logic           le_i_ready,
  input  logic [31:0]    le_i_wdat,
  input  logic [RDW-1:0] le_i_rdidx,
  output logic           wbck_o_valid,
  input  logic           wbck_o_ready,
  output logic [31:0]    wbck_o_wdat,
  output logic [RDW-1:0] wbck_o_rdidx,
  output logic [1:0]     wbck_o_src,
  output logic           cmp_busy
);

  localparam int EW = 32 + RDW + 2;

  logic [1:0]    rr_ptr_q, rr_ptr_d;
  logic [3:0]    req;
  logic [1:0]    p0, p1, p2;
  logic [1:0]    gidx;
  logic          gany;
  logic          full, empty, byp, push, pop;
  logic [EW-1:0] gent, head, out_ent;

  assign req = {1'b0, le_i_valid, lt_i_valid, eq_i_valid};
  assign p0  = rr_ptr_q;
  assign p1  = rr_next(p0);
  assign p2  = rr_next(p1);

  // Readys depend only on full, rr_ptr and the valids; never on wbck_o_ready.
  always_comb begin
    gidx = p0;
    gany = 1'b0;
    if (!full) begin
      if (req[p0]) begin
        gidx = p0;
        gany = 1'b1;
      end else if (req[p1]) begin
        gidx = p1;
        gany = 1'b1;
      end else if (req[p2]) begin
        gidx = p2;
        gany = 1'b1;
      end
    end
  end

  assign eq_i_ready = gany && (gidx == CMP_SRC_EQ);
  assign lt_i_ready = gany && (gidx == CMP_SRC_LT);
  assign le_i_ready = gany && (gidx == CMP_SRC_LE);

  always_comb begin
    gent = {CMP_SRC_EQ, eq_i_rdidx, fcmp_norm(eq_i_wdat)};
    case (gidx)
      CMP_SRC_LT: gent = {CMP_SRC_LT, lt_i_rdidx, fcmp_norm(lt_i_wdat)};
      CMP_SRC_LE: gent = {CMP_SRC_LE, le_i_rdidx, fcmp_norm(le_i_wdat)};
      default:    gent = {CMP_SRC_EQ, eq_i_rdidx, fcmp_norm(eq_i_wdat)};
    endcase
  end

  assign rr_ptr_d = gany ? rr_next(gidx) : rr_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 2'd0;
    else        rr_ptr_q <= rr_ptr_d;
  end

`ifdef E203_FPU_CMP_WBCK_BYPASS_EN
  assign byp = gany && empty && wbck_o_ready;
`else
  assign byp = 1'b0;
`endif

  assign push = gany && !byp;
  assign pop  = wbck_o_ready && !empty;

  e203_exu_fpu_cmp_wbck_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (gent),
    .pop_i   (pop),
    .dout_o  (head),
    .full_o  (full),
    .empty_o (empty)
  );

  // Fields are forced to zero while invalid so stale storage never leaks out.
  assign out_ent      = empty ? gent : head;
  assign wbck_o_valid = !empty || byp;
  assign wbck_o_wdat  = wbck_o_valid ? out_ent[31:0] : FCMP_FALSE;
  assign wbck_o_rdidx = wbck_o_valid ? out_ent[32 +: RDW] : '0;
  assign wbck_o_src   = wbck_o_valid ? out_ent[EW-1 -: 2] : CMP_SRC_EQ;
  assign cmp_busy     = !empty;

endmodule

// File: tb/tb_e203_exu_fpu_cmp_wbck.sv
// Directed-vector bench for the FPU compare writeback collector (default build, DEPTH=2).
module tb_e203_exu_fpu_cmp_wbck;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        eq_i_valid = 0, lt_i_valid = 0, le_i_valid = 0;
  logic        eq_i_ready, lt_i_ready, le_i_ready;
  logic [31:0] eq_i_wdat = 0, lt_i_wdat = 0, le_i_wdat = 0;
  logic [4:0]  eq_i_rdidx = 0, lt_i_rdidx = 0, le_i_rdidx = 0;
  logic        wbck_o_valid, wbck_o_ready = 0;
  logic [31:0] wbck_o_wdat;
  logic [4:0]  wbck_o_rdidx;
  logic [1:0]  wbck_o_src;
  logic        cmp_busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  e203_exu_fpu_cmp_wbck #(.DEPTH(2), .RDW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .eq_i_valid(eq_i_valid), .eq_i_ready(eq_i_ready), .eq_i_wdat(eq_i_wdat), .eq_i_rdidx(eq_i_rdidx),
    .lt_i_valid(lt_i_valid), .lt_i_ready(lt_i_ready), .lt_i_wdat(lt_i_wdat), .lt_i_rdidx(lt_i_rdidx),
    .le_i_valid(le_i_valid), .le_i_ready(le_i_ready), .le_i_wdat(le_i_wdat), .le_i_rdidx(le_i_rdidx),
    .wbck_o_valid(wbck_o_valid), .wbck_o_ready(wbck_o_ready), .wbck_o_wdat(wbck_o_wdat),
    .wbck_o_rdidx(wbck_o_rdidx), .wbck_o_src(wbck_o_src), .cmp_busy(cmp_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_valids(input logic e, input logic t, input logic l);
    eq_i_valid = e;
    lt_i_valid = t;
    le_i_valid = l;
  endtask

  logic [2:0] exp_rdy [6];
  logic [1:0] exp_src [6];

  initial begin
    exp_rdy[0] = 3'b001; exp_rdy[1] = 3'b010; exp_rdy[2] = 3'b100;
    exp_rdy[3] = 3'b001; exp_rdy[4] = 3'b010; exp_rdy[5] = 3'b100;
    exp_src[0] = 2'd0; exp_src[1] = 2'd1; exp_src[2] = 2'd2;
    exp_src[3] = 2'd0; exp_src[4] = 2'd1; exp_src[5] = 2'd2;

    // Reset state
    do_reset();
    check("rst_valid", {31'b0, wbck_o_valid}, 32'h0);
    check("rst_wdat", wbck_o_wdat, 32'h0);
    check("rst_rdidx", {27'b0, wbck_o_rdidx}, 32'h0);
    check("rst_src", {30'b0, wbck_o_src}, 32'h0);
    check("rst_busy", {31'b0, cmp_busy}, 32'h0);
    check("rst_readys", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h0);

    // Single lt request, 1-cycle latency
    wbck_o_ready = 1'b1;
    lt_i_wdat = 32'h1; lt_i_rdidx = 5'd5;
    set_valids(0, 1, 0);
    #1 check("single_rdy", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h2);
    check("single_val0", {31'b0, wbck_o_valid}, 32'h0);
    @(negedge clk);
    set_valids(0, 0, 0);
    check("single_valid", {31'b0, wbck_o_valid}, 32'h1);
    check("single_wdat", wbck_o_wdat, 32'h1);
    check("single_rdidx", {27'b0, wbck_o_rdidx}, 32'd5);
    check("single_src", {30'b0, wbck_o_src}, 32'd1);
    @(negedge clk);
    check("single_drained", {31'b0, wbck_o_valid}, 32'h0);

    // Round-robin with all three valid; eq non-boolean, lt zero, le small
    do_reset();
    eq_i_wdat = 32'hFFFF_0000; eq_i_rdidx = 5'd1;
    lt_i_wdat = 32'h0;         lt_i_rdidx = 5'd2;
    le_i_wdat = 32'h5;         le_i_rdidx = 5'd3;
    set_valids(1, 1, 1);
    for (int i = 0; i < 6; i++) begin
      #1 check($sformatf("rr_rdy%0d", i), {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, {29'b0, exp_rdy[i]});
      @(negedge clk);
      check($sformatf("rr_src%0d", i), {30'b0, wbck_o_src}, {30'b0, exp_src[i]});
      check($sformatf("rr_wdat%0d", i), wbck_o_wdat, (exp_src[i] == 2'd1) ? 32'h0 : 32'h1);
      check($sformatf("rr_rdidx%0d", i), {27'b0, wbck_o_rdidx}, {30'b0, exp_src[i]} + 32'd1);
    end

    // Backpressure: two grants fill the FIFO, then all readys drop
    do_reset();
    wbck_o_ready = 1'b0;
    #1 check("bp_rdy0", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h1);
    @(negedge clk);
    check("bp_rdy1", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h2);
    @(negedge clk);
    check("bp_full_rdy", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h0);
    check("bp_busy", {31'b0, cmp_busy}, 32'h1);
    @(negedge clk);
    check("bp_hold_src", {30'b0, wbck_o_src}, 32'd0);
    check("bp_hold_rdy", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h0);
    @(negedge clk);
    // Full with pop this cycle: no ready may assert
    wbck_o_ready = 1'b1;
    #1 check("full_pop_rdy", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h0);
    check("drain0_src", {30'b0, wbck_o_src}, 32'd0);
    @(negedge clk);
    check("drain1_src", {30'b0, wbck_o_src}, 32'd1);
    check("drain1_rdy", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h4);
    @(negedge clk);
    set_valids(0, 0, 0);
    check("drain2_src", {30'b0, wbck_o_src}, 32'd2);
    check("drain2_wdat", wbck_o_wdat, 32'h1);
    @(negedge clk);
    check("drain_empty", {31'b0, cmp_busy}, 32'h0);

    // Reset while two entries are buffered
    wbck_o_ready = 1'b0;
    set_valids(1, 1, 1);
    repeat (3) @(negedge clk);
    check("prerst_busy", {31'b0, cmp_busy}, 32'h1);
    #2 rst_n = 1'b0;
    #1 check("midrst_valid", {31'b0, wbck_o_valid}, 32'h0);
    check("midrst_busy", {31'b0, cmp_busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("postrst_rdy", {29'b0, le_i_ready, lt_i_ready, eq_i_ready}, 32'h1);
    set_valids(0, 0, 0);

    // Zero input on eq yields zero output
    @(negedge clk);
    eq_i_wdat = 32'h0; eq_i_rdidx = 5'd9;
    set_valids(1, 0, 0);
    wbck_o_ready = 1'b1;
    repeat (2) @(negedge clk);
    set_valids(0, 0, 0);
    check("zero_wdat", wbck_o_wdat, 32'h0);
    check("zero_valid", {31'b0, wbck_o_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
